pov_spi_rx: RTL
===============

Name: pov_spi_rx

Overview:
- SPI responder (mode 0) that receives a new point-of-view from an external MCU: player position, facing vector and view-plane vector.
- Drives raybox's write_new_position and new_playerX..new_vplaneY ports, so the MCU can drive the raycaster instead of the K1..K4 buttons.
- A received frame is staged first. It is committed to the outputs only on a frame-boundary strobe, so the view never changes mid-frame.
- Sits in the board wrapper beside raybox, in the raybox clock domain; SPI pins arrive on gpio1.

Parameters:
- VEC_W, 16: width of each vector component, raw fixed-point bits, no interpretation.
- NVEC, 6: number of components per frame.
- ERRW, 8: width of the error counter.

Ports:
- clk  in  1  raybox pixel clock (25 MHz).
- reset  in  1  asynchronous, active-low; all state cleared while low.
- spi_sclk  in  1  SPI clock from MCU; asynchronous to clk.
- spi_mosi  in  1  SPI data, sampled on sclk rising edge.
- spi_csb  in  1  chip select, active-low, frames a transfer.
- load_ok  in  1  one-clk strobe at the start of vertical blank (vsync-derived).
- write_new_position  out  1  one-clk pulse when new_* update.
- new_playerX, new_playerY, new_facingX, new_facingY, new_vplaneX, new_vplaneY  out  VEC_W each  committed POV.
- pending  out  1  a staged frame is waiting for load_ok.
- overrun  out  1  sticky: a staged frame was replaced before it was applied.
- err_count  out  ERRW  saturating count of discarded frames.

Behaviour:
- Input sync: sclk, mosi and csb each pass through 2-FF synchronisers. Edge detection uses a third registered stage.
- SPI timing constraints: sclk ≤ clk/4; csb setup and hold ≥ 2 clk around the first and last sclk edges.
- Frame format: exactly NVEC*VEC_W = 96 bits, MSB first, sent in order playerX, playerY, facingX, facingY, vplaneX, vplaneY.
- Bit counter is 7 bits and saturates at 97; anything >96 is treated as "too long".
- FSM states:
  - IDLE: waits for a synced csb falling edge, then clears the bit counter and goes to SHIFT.
  - SHIFT: on each synced sclk rising edge, shifts mosi into a 96-bit register and increments the counter. On synced csb rising edge, goes to CHECK.
  - CHECK: one cycle. If count == 96, copies the shift register into the staging registers and sets pending; if pending was already 1, also sets overrun. Otherwise discards the frame and increments err_count (saturates at all-ones). Always returns to IDLE.
- A csb falling edge while in CHECK is not possible, because of the csb hold constraint. A falling edge seen in SHIFT restarts the count, since csb must have risen first.
- Commit:
  - In any cycle where load_ok=1 and pending=1 (registered value), on the next edge: new_* ← staging, write_new_position=1 for exactly one clk, pending cleared.
  - load_ok with pending=0 does nothing.
- Simultaneous CHECK-accept and load_ok: the commit uses the old staged frame if pending was 1. The new frame then stays pending; overrun is not set, because the old frame was consumed. There is no same-cycle bypass.
- Latency: csb rise to pending=1 is ≤5 clk (3 sync/edge + CHECK + register).
- Reset values: all new_* = 0, write_new_position = 0, pending = 0, overrun = 0, err_count = 0, FSM = IDLE, counter = 0.
- Reset asserted mid-transfer aborts the frame. After release, the block waits for a fresh csb fall; the remainder of an in-progress transfer is ignored.
- new_* are only ever written by a commit; they hold between commits.
- mosi is ignored while csb is high.

Test Plan:
- Valid frame: send 96 bits with playerX=16'h0580, playerY=16'h0A40, facingX=16'h0100, facingY=0, vplaneX=0, vplaneY=16'h00C0, then pulse load_ok → one write_new_position pulse, new_* equal those values, pending 1→0, err_count=0.
- Short/long frames: send 95 bits, then 97 bits → both discarded, err_count=2, pending=0, new_* unchanged.
- Overrun: send frame A (playerX=16'h0111), then frame B (playerX=16'h0222), then load_ok → new_playerX=16'h0222, overrun=1, exactly one pulse.
- Boundary: load_ok asserted in the same cycle as CHECK accepts frame B while frame A is pending → A committed, pending stays 1. Next load_ok commits B; overrun=0.
- Idle strobe and reset: load_ok with nothing pending → no pulse. Assert reset after 40 bits, release, send a full valid frame plus load_ok → correct values, err_count=0.
- Saturation: 300 bad frames → err_count=8'hFF.

Source files
------------

// File: rtl/pov_spi_rx.sv
// SPI mode-0 responder that receives a player point-of-view frame from an MCU.
// The frame is held in a staging buffer and applied to raybox only on load_ok.
module pov_spi_rx #(
    parameter int VEC_W = 16,
    parameter int NVEC  = 6,
    parameter int ERRW  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spi_sclk,
    input  logic             spi_mosi,
    input  logic             spi_csb,
    input  logic             load_ok,
    output logic             write_new_position,
    output logic [VEC_W-1:0] new_playerX,
    output logic [VEC_W-1:0] new_playerY,
    output logic [VEC_W-1:0] new_facingX,
    output logic [VEC_W-1:0] new_facingY,
    output logic [VEC_W-1:0] new_vplaneX,
    output logic [VEC_W-1:0] new_vplaneY,
    output logic             pending,
    output logic             overrun,
    output logic [ERRW-1:0]  err_count
);

    localparam int FW = NVEC * VEC_W;
    localparam int CW = $clog2(FW + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(FW);
    localparam logic [CW-1:0] CNT_SAT  = CW'(FW + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      sclkSync_q;
    logic [2:0]      csbSync_q;
    logic [1:0]      mosiSync_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [FW-1:0]   shift_q, shift_d;
    logic [FW-1:0]   stage_q, stage_d;
    logic [FW-1:0]   pov_q, pov_d;
    logic            pending_q, pending_d;
    logic            overrun_q, overrun_d;
    logic            wnp_q, wnp_d;
    logic [ERRW-1:0] err_q, err_d;

    logic sclkRise, csbRise, csbFall, mosiBit;
    logic accept, reject, commit;

    // csb syncs reset low so a select already held low at release is not
    // mistaken for a fresh falling edge; the rest of that transfer is ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclkSync_q <= '0;
            csbSync_q  <= '0;
            mosiSync_q <= '0;
        end else begin
            sclkSync_q <= {sclkSync_q[1:0], spi_sclk};
            csbSync_q  <= {csbSync_q[1:0], spi_csb};
            mosiSync_q <= {mosiSync_q[0], spi_mosi};
        end
    end

    assign sclkRise = sclkSync_q[1] & ~sclkSync_q[2];
    assign csbRise  = csbSync_q[1] & ~csbSync_q[2];
    assign csbFall  = ~csbSync_q[1] & csbSync_q[2];
    assign mosiBit  = mosiSync_q[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            stage_q   <= '0;
            pov_q     <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            wnp_q     <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            stage_q   <= stage_d;
            pov_q     <= pov_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            wnp_q     <= wnp_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        stage_d   = stage_q;
        pov_d     = pov_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        wnp_d     = 1'b0;
        err_d     = err_q;
        accept    = 1'b0;
        reject    = 1'b0;
        commit    = load_ok & pending_q;

        case (state_q)
            IDLE: begin
                if (csbFall) begin
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (csbRise) begin
                    state_d = CHECK;
                end else if (csbFall) begin
                    cnt_d = '0;
                end else if (sclkRise) begin
                    shift_d = {shift_q[FW-2:0], mosiBit};
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (cnt_q == CNT_FULL) begin
                    accept = 1'b1;
                end else begin
                    reject = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Commit reads the old staged frame, so an accept in the same cycle
        // simply becomes the next pending frame without counting as overrun.
        if (commit) begin
            pov_d     = stage_q;
            wnp_d     = 1'b1;
            pending_d = 1'b0;
        end
        if (accept) begin
            stage_d   = shift_q;
            pending_d = 1'b1;
            if (pending_q && !commit) begin
                overrun_d = 1'b1;
            end
        end
        if (reject && (err_q != '1)) begin
            err_d = err_q + ERRW'(1);
        end
    end

    assign write_new_position = wnp_q;
    assign pending            = pending_q;
    assign overrun            = overrun_q;
    assign err_count          = err_q;
    assign new_playerX        = pov_q[(NVEC-0)*VEC_W-1 -: VEC_W];
    assign new_playerY        = pov_q[(NVEC-1)*VEC_W-1 -: VEC_W];
    assign new_facingX        = pov_q[(NVEC-2)*VEC_W-1 -: VEC_W];
    assign new_facingY        = pov_q[(NVEC-3)*VEC_W-1 -: VEC_W];
    assign new_vplaneX        = pov_q[(NVEC-4)*VEC_W-1 -: VEC_W];
    assign new_vplaneY        = pov_q[(NVEC-5)*VEC_W-1 -: VEC_W];

endmodule
